// File: rtl/melody_pkg.sv
// Shared types, FSM encoding and melody ROM contents for the melody sequencer.
package melody_pkg;

  localparam int unsigned NOTE_W  = 7;
  localparam int unsigned DUR_W   = 8;
  localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  localparam logic [DUR_W-1:0]  DUR_END   = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  // Melody table; any entry not listed reads as an end marker.
  function automatic rom_entry_t rom_lookup(input int unsigned mel, input int unsigned step);
    rom_entry_t e;
    e = '0;
    case (mel)
      0: begin
        case (step)
          0:       e = '{note: 7'd5, dur: 8'd2};
          1:       e = '{note: 7'd0, dur: 8'd1};
          2:       e = '{note: 7'd9, dur: 8'd1};
          default: e = '0;
        endcase
      end
      1: e = '{note: NOTE_W'(step + 1), dur: 8'd1};
      2: begin
        case (step)
          0:       e = '{note: 7'd12, dur: 8'd1};
          1:       e = '{note: 7'd3,  dur: 8'd3};
          default: e = '0;
        endcase
      end
      3: begin
        case (step)
          0:       e = '{note: 7'd127, dur: 8'd2};
          1:       e = '{note: 7'd1,   dur: 8'd1};
          default: e = '0;
        endcase
      end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Synchronous melody ROM, one cycle read latency, addressed by {melody, step}.
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned MEL_BITS  = 3,
  parameter int unsigned STEP_BITS = 5
) (
  input  logic                          CLOCK_50,
  input  logic [MEL_BITS+STEP_BITS-1:0] addr,
  output rom_entry_t                    data
);

  always_ff @(posedge CLOCK_50) begin
    data <= rom_lookup(int'(addr[MEL_BITS+STEP_BITS-1:STEP_BITS]), int'(addr[STEP_BITS-1:0]));
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a melody ROM, driving NOTE's tone select and enable for each note's
// duration with a silent gap between notes; supports start, stop and loop.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_CYC   = 1000000,
  parameter int unsigned MEL_BITS  = 3,
  parameter int unsigned STEP_BITS = 5
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic [MEL_BITS-1:0]  melody_sel,
  output logic [NOTE_W-1:0]    note_sel,
  output logic                 note_en,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_BITS-1:0] step_idx
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned ADDR_W = MEL_BITS + STEP_BITS;

  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [STEP_BITS-1:0] STEP_LAST = '1;

  logic [2:0]           state, state_n;
  logic [MEL_BITS-1:0]  mel, mel_n;
  logic [STEP_BITS-1:0] step_n;
  logic [TICK_W-1:0]    tick, tick_n;
  logic [DUR_W-1:0]     dur_cnt, dur_cnt_n;
  logic [DUR_W-1:0]     dur_q, dur_q_n;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
  logic [NOTE_W-1:0]    note_sel_n;
  logic                 note_en_n, busy_n, done_n;
  logic                 end_seq;
  logic [ADDR_W-1:0]    rom_addr;
  rom_entry_t           rom_q;

  assign rom_addr = {mel, step_idx};

  melody_rom #(
    .MEL_BITS  (MEL_BITS),
    .STEP_BITS (STEP_BITS)
  ) u_rom (
    .CLOCK_50 (CLOCK_50),
    .addr     (rom_addr),
    .data     (rom_q)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= S_IDLE;
      mel      <= '0;
      step_idx <= '0;
      tick     <= '0;
      dur_cnt  <= '0;
      dur_q    <= '0;
      gap_cnt  <= '0;
      note_sel <= '0;
      note_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      mel      <= mel_n;
      step_idx <= step_n;
      tick     <= tick_n;
      dur_cnt  <= dur_cnt_n;
      dur_q    <= dur_q_n;
      gap_cnt  <= gap_cnt_n;
      note_sel <= note_sel_n;
      note_en  <= note_en_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_n    = state;
    mel_n      = mel;
    step_n     = step_idx;
    tick_n     = tick;
    dur_cnt_n  = dur_cnt;
    dur_q_n    = dur_q;
    gap_cnt_n  = gap_cnt;
    note_sel_n = note_sel;
    note_en_n  = note_en;
    done_n     = 1'b0;
    end_seq    = 1'b0;

    if (state != S_IDLE && stop) begin
      state_n    = S_IDLE;
      step_n     = '0;
      note_sel_n = '0;
      note_en_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            mel_n   = melody_sel;
            step_n  = '0;
            state_n = S_FETCH;
          end
        end
        S_FETCH: state_n = S_LOAD;
        S_LOAD: begin
          if (rom_q.dur != DUR_END) begin
            state_n    = S_PLAY;
            note_sel_n = rom_q.note;
            note_en_n  = (rom_q.note != NOTE_REST);
            dur_q_n    = rom_q.dur;
            tick_n     = '0;
            dur_cnt_n  = '0;
          end else begin
            end_seq = 1'b1;
          end
        end
        S_PLAY: begin
          if (tick == TICK_LAST) begin
            tick_n = '0;
            if (dur_cnt == dur_q - DUR_W'(1)) begin
              state_n    = S_GAP;
              note_sel_n = '0;
              note_en_n  = 1'b0;
              gap_cnt_n  = '0;
            end else begin
              dur_cnt_n = dur_cnt + DUR_W'(1);
            end
          end else begin
            tick_n = tick + TICK_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (step_idx == STEP_LAST) begin
              end_seq = 1'b1;
            end else begin
              step_n  = step_idx + STEP_BITS'(1);
              state_n = S_FETCH;
            end
          end else begin
            gap_cnt_n = gap_cnt + GAP_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // End of melody: restart when looping, otherwise return to idle with a done pulse.
    if (end_seq) begin
      step_n = '0;
      if (loop) begin
        state_n = S_FETCH;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized bench for melody_sequencer: a per-cycle expected-output queue is built from
// the melody table and timing rules, and every output is compared each cycle.
module tb_melody_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [2:0] melody_sel = '0;
  logic [6:0] note_sel;
  logic       note_en, busy, done;
  logic [4:0] step_idx;

  melody_sequencer #(
    .TICK_DIV  (TICK),
    .GAP_CYC   (GAP),
    .MEL_BITS  (3),
    .STEP_BITS (5)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .melody_sel (melody_sel),
    .note_sel   (note_sel),
    .note_en    (note_en),
    .busy       (busy),
    .done       (done),
    .step_idx   (step_idx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic       done;
    logic       busy;
    logic       en;
    logic [6:0] sel;
    logic [4:0] step;
    logic       end_here;
  } item_t;

  item_t q[$];
  item_t cur;
  int    mel_l;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected melody contents: (note, dur); dur 0 ends the melody.
  function automatic void mel_entry(input int m, input int s, output int note, output int dur);
    note = 0;
    dur  = 0;
    if (m == 0) begin
      if (s == 0) begin note = 5; dur = 2; end
      else if (s == 1) begin note = 0; dur = 1; end
      else if (s == 2) begin note = 9; dur = 1; end
    end else if (m == 1) begin
      note = s + 1;
      dur  = 1;
    end else if (m == 2) begin
      if (s == 0) begin note = 12; dur = 1; end
      else if (s == 1) begin note = 3; dur = 3; end
    end else if (m == 3) begin
      if (s == 0) begin note = 127; dur = 2; end
      else if (s == 1) begin note = 1; dur = 1; end
    end
  endfunction

  function automatic item_t mk(input logic d, input logic b, input logic e, input int sel,
                               input int step, input logic eh);
    item_t it;
    it.done = d;
    it.busy = b;
    it.en   = e;
    it.sel  = 7'(sel);
    it.step = 5'(step);
    it.end_here = eh;
    return it;
  endfunction

  // One pass through a melody: fetch+load per step, dur*TICK play cycles, GAP silent cycles.
  function automatic void build(input int m);
    int note, dur;
    for (int s = 0; s < 32; s++) begin
      mel_entry(m, s, note, dur);
      q.push_back(mk(1'b0, 1'b1, 1'b0, 0, s, 1'b0));
      q.push_back(mk(1'b0, 1'b1, 1'b0, 0, s, dur == 0));
      if (dur == 0) return;
      for (int k = 0; k < dur * TICK; k++) q.push_back(mk(1'b0, 1'b1, note != 0, note, s, 1'b0));
      for (int g = 0; g < GAP; g++) q.push_back(mk(1'b0, 1'b1, 1'b0, 0, s, (s == 31) && (g == GAP - 1)));
    end
  endfunction

  // Advance the reference by one clock edge using the inputs presented at that edge.
  function automatic void model_edge();
    if (reset) begin
      q.delete();
      cur = '0;
    end else if (cur.busy && stop) begin
      q.delete();
      cur = '0;
    end else if (!cur.busy && start && !stop) begin
      q.delete();
      mel_l = int'(melody_sel);
      build(mel_l);
      cur = q.pop_front();
    end else if (cur.busy && cur.end_here) begin
      q.delete();
      if (loop) begin
        build(mel_l);
        cur = q.pop_front();
      end else begin
        cur = mk(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
  endfunction

  task automatic cycle();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check_eq("note_sel", 32'(note_sel), 32'(cur.sel));
    check_eq("note_en",  32'(note_en),  32'(cur.en));
    check_eq("busy",     32'(busy),     32'(cur.busy));
    check_eq("done",     32'(done),     32'(cur.done));
    check_eq("step_idx", 32'(step_idx), 32'(cur.step));
    if (done) n_done++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start(input int m);
    melody_sel = 3'(m);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    cur = '0;
    mel_l = 0;
    reset = 1'b1;
    start = 1'b1;
    run(3);
    reset = 1'b0;
    start = 1'b0;
    run(2);

    pulse_start(0);
    run(45);
    pulse_start(1);
    run(300);
    loop = 1'b1;
    pulse_start(0);
    run(90);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    loop = 1'b0;
    pulse_start(2);
    run(10);
    melody_sel = 3'd3;
    start = 1'b1;
    run(3);
    start = 1'b0;
    run(30);
    pulse_start(3);
    run(14);
    reset = 1'b1;
    start = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    start = 1'b0;
    run(40);

    for (int i = 0; i < 6000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      stop       = (i >= 3000) && ($urandom_range(0, 59) == 0);
      reset      = (i >= 3000) && ($urandom_range(0, 399) == 0);
      melody_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) loop = ~loop;
      cycle();
    end
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
    loop  = 1'b0;
    run(400);

    check_eq("done_seen", 32'(n_done > 0), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
